dcache_refill_buffer: RTL
=========================

# dcache_refill_buffer

Line-refill assembler for the data cache, directly upstream of the distributed-RAM data array. It accepts a miss request, collects four 32-bit critical-word-first wrapping bus beats, merges the pending store that caused the miss, and then writes the full 128-bit line into the data array in a single cycle. It also asserts a done pulse so the cache controller can resume.

## Interface
- BYTE_WIDTH, 8, byte-lane width; ram_strobe has one bit per byte.
- INDEX_BITS, Dcache_index_bits, width of the line index / data-array address.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  refill request.
- req_ready  out  1  high only in IDLE.
- req_index  in  INDEX_BITS  line index to fill.
- req_crit  in  2  word offset of the first beat (the critical word).
- st_en  in  1  a store is pending to this line; sampled with the request.
- st_word  in  2  word offset of the store.
- st_strobe  in  4  store byte enables.
- st_data  in  32  store data.
- beat_valid  in  1  bus beat valid.
- beat_ready  out  1  high only in FILL.
- beat_data  in  32  beat payload.
- beat_last  in  1  bus marks final beat.
- ram_addr  out  INDEX_BITS  data-array address.
- ram_strobe  out  16  data-array byte write enables.
- ram_wdata  out  128  assembled line.
- done  out  1  one-cycle pulse; line written this cycle.
- err  out  1  sticky beat_last protocol error.
- crit_valid  out  1  critical word available (see Configuration).
- crit_data  out  32  merged critical word.

## Operation
- States: IDLE, FILL, WRITE.
- IDLE, req_valid&req_ready:
  - latch index, crit, st_*;
  - set wptr=req_crit, cnt=0, clear err;
  - go to FILL.
- FILL, beat_valid&beat_ready:
  - write line word[wptr] = beat_data;
  - if st_en and st_word==wptr, replace each byte i that has st_strobe[i]=1 with st_data byte i;
  - wptr=wptr+1 mod 4 (wraps 3->0); cnt=cnt+1.
  - On the 4th beat (cnt==3), go to WRITE.
- beat_last is checked, not trusted:
  - beat_last=1 on beats 1-3 sets err;
  - beat_last=0 on beat 4 sets err.
  - Either way, the beat count alone ends FILL.
  - err holds until the next request is accepted.
- WRITE, one cycle:
  - ram_addr=latched index, ram_strobe=16'hFFFF, ram_wdata=line, done=1;
  - next state IDLE.
- Outside WRITE: ram_strobe=0, done=0; ram_addr/ram_wdata hold their last values.
- Line word w occupies ram_wdata bits [32w+31:32w]; byte b of word w maps to ram_strobe bit 4w+b.
- The store merge is applied exactly once, to the beat that lands on st_word; a store with all-zero strobe leaves data unchanged.

## Timing
- Reset values: state IDLE, req_ready=1, beat_ready=0, ram_strobe=0, ram_addr=0, ram_wdata=0, done=0, err=0, crit_valid=0, crit_data=0.
- Request accepted at edge T. Beats are accepted at earliest T+1..T+4. WRITE occupies cycle T+5 and req_ready returns at T+6.
- Minimum request-to-request spacing is 6 cycles. beat_valid gaps stall FILL indefinitely with no timeout.
- req_ready and beat_ready are registered-state decodes with no combinational path from valid inputs.
- ram_strobe/ram_wdata/ram_addr are valid during the WRITE cycle. The array captures them on the edge ending WRITE.
- beat_valid asserted in IDLE or WRITE is ignored (beat_ready=0).
- reset asserted in any state:
  - next cycle is IDLE, the partial line is discarded and no RAM write occurs;
  - if reset coincides with the WRITE cycle, the write edge is suppressed (ram_strobe forced 0 while reset=1).

## Configuration
- DCACHE_REFILL_CRIT_FWD_EN defined:
  - crit_valid pulses high for one cycle, the cycle after the first beat handshake;
  - crit_data = first beat after store merge, so the load can complete early.
- Undefined: crit_valid and crit_data are constant 0 and the forwarding registers are removed; the line write path is unchanged.

## Test plan
- Index 5, crit=0, beats 0x11111111,0x22222222,0x33333333,0x44444444 (last on 4th), no store -> WRITE at T+5 with ram_addr=5, ram_strobe=16'hFFFF, ram_wdata=0x44444444_33333333_22222222_11111111, done=1, err=0.
- crit=2, same beats -> wrap order: word2=0x11111111, word3=0x22222222, word0=0x33333333, word1=0x44444444.
- st_en, st_word=1, st_strobe=4'b0101, st_data=0xAABBCCDD, crit=0, beats all 0x00000000 -> word1=0x00BB00DD, other words 0.
- beat_last on 2nd beat -> err=1 after that beat, fill still takes 4 beats and writes; err clears on the next accept.
- Reset after 2 beats -> IDLE next cycle, ram_strobe never nonzero, req_ready=1.
- With DCACHE_REFILL_CRIT_FWD_EN, crit=3, first beat 0xDEADBEEF -> crit_valid one cycle, crit_data=0xDEADBEEF; with beat_valid held low 3 cycles between beats -> done only after the 4th beat.

Source files
------------

// File: rtl/dcache_refill_buffer.sv
// Data-cache line refill assembler: gathers four wrapping 32-bit beats, merges the pending store, writes a 128-bit line.
// Optional critical-word forwarding is enabled by defining DCACHE_REFILL_CRIT_FWD_EN.
module dcache_refill_buffer #(
  parameter int BYTE_WIDTH = 8,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [1:0]            req_crit,
  input  logic                  st_en,
  input  logic [1:0]            st_word,
  input  logic [3:0]            st_strobe,
  input  logic [31:0]           st_data,
  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [31:0]           beat_data,
  input  logic                  beat_last,
  output logic [INDEX_BITS-1:0] ram_addr,
  output logic [15:0]           ram_strobe,
  output logic [127:0]          ram_wdata,
  output logic                  done,
  output logic                  err,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                state, state_nxt;
  logic [INDEX_BITS-1:0] idx_q;
  logic [1:0]            wptr, cnt;
  logic                  st_en_q;
  logic [1:0]            st_word_q;
  logic [3:0]            st_strobe_q;
  logic [31:0]           st_data_q;
  logic [31:0]           line_q [4];
  logic                  req_fire, beat_fire;
  logic [31:0]           beat_merged;
  logic [127:0]          line_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready is a pure decode of the registered state and never looks at valid.
  assign req_ready  = (state == IDLE);
  assign beat_ready = (state == FILL);
  assign req_fire   = req_valid & req_ready;
  assign beat_fire  = beat_valid & beat_ready;
  assign dbg_state  = state;

  // Reset overrides the write strobe combinationally so a WRITE cycle under reset never commits.
  assign ram_strobe = ((state == WRITE) && !reset) ? 16'hFFFF : 16'h0000;
  assign done       = (state == WRITE) && !reset;

  always_comb begin
    beat_merged = beat_data;
    if (st_en_q && (st_word_q == wptr)) begin
      for (int i = 0; i < 4; i++) begin
        if (st_strobe_q[i]) begin
          beat_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = st_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    line_next = '0;
    for (int w = 0; w < 4; w++) begin
      line_next[32*w +: 32] = (2'(w) == wptr) ? beat_merged : line_q[w];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = FILL;
      FILL:    if (beat_fire && (cnt == 2'd3)) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx_q       <= '0;
      wptr        <= '0;
      cnt         <= '0;
      st_en_q     <= 1'b0;
      st_word_q   <= '0;
      st_strobe_q <= '0;
      st_data_q   <= '0;
      err         <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      for (int w = 0; w < 4; w++) line_q[w] <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        idx_q       <= req_index;
        st_en_q     <= st_en;
        st_word_q   <= st_word;
        st_strobe_q <= st_strobe;
        st_data_q   <= st_data;
        wptr        <= req_crit;
        cnt         <= '0;
        err         <= 1'b0;
      end
      if (beat_fire) begin
        line_q[wptr] <= beat_merged;
        wptr         <= wptr + 2'd1;
        cnt          <= cnt + 2'd1;
        // beat_last is only audited; the beat count alone ends the fill.
        if (beat_last != (cnt == 2'd3)) err <= 1'b1;
        if (cnt == 2'd3) begin
          ram_addr  <= idx_q;
          ram_wdata <= line_next;
        end
      end
    end
  end

`ifdef DCACHE_REFILL_CRIT_FWD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= beat_fire && (cnt == 2'd0);
      if (beat_fire && (cnt == 2'd0)) crit_data <= beat_merged;
    end
  end
`else
  assign crit_valid = 1'b0;
  assign crit_data  = 32'h0;
`endif

endmodule
